// File: rtl/sha256_kdf_seq.sv
// Buffers 16-word message blocks, streams each into a SHA256 core after a start-of-block strobe, then reads the 8-word digest.
// Upstream stalls via s_ready outside FILL; each digest word appears one cycle after its core_rd, done one cycle after H7.
module sha256_kdf_seq #(
  parameter int TIMEOUT = 64,
  parameter int MAX_BLK = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  nblocks,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] core_data,
  output logic        core_soc,
  output logic        core_rd,
  input  logic        core_eoc,
  input  logic [31:0] core_hash,
  output logic [31:0] h_data,
  output logic        h_valid,
  output logic        h_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FILL, SOC, LOAD, WAIT, READ, ERR} state_t;

  state_t        state;
  logic [3:0]    blk_left;
  logic [3:0]    wcnt;
  logic [3:0]    rcnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   mem [16];
  logic          xfer;

  assign xfer = (state == FILL) && s_valid && s_ready;

  // Block buffer needs no reset: every word is rewritten before it is loaded.
  always_ff @(posedge clk) begin
    if (xfer) mem[wcnt] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      blk_left  <= 4'd0;
      wcnt      <= 4'd0;
      rcnt      <= 4'd0;
      tcnt      <= '0;
      s_ready   <= 1'b0;
      core_data <= 32'h0;
      core_soc  <= 1'b0;
      core_rd   <= 1'b0;
      h_data    <= 32'h0;
      h_valid   <= 1'b0;
      h_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      core_soc <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      // Digest path is a one-stage pipe behind core_rd.
      h_valid  <= core_rd;
      h_last   <= core_rd && (rcnt == 4'd7);
      h_data   <= core_rd ? core_hash : 32'h0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (nblocks != 4'd0 && nblocks <= 4'(MAX_BLK)) begin
              state    <= FILL;
              blk_left <= nblocks;
              wcnt     <= 4'd0;
              s_ready  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        FILL: begin
          if (xfer) begin
            if (wcnt == 4'd15) begin
              state    <= SOC;
              wcnt     <= 4'd0;
              s_ready  <= 1'b0;
              core_soc <= 1'b1;
            end else begin
              wcnt <= wcnt + 4'd1;
            end
          end
        end
        SOC: begin
          state     <= LOAD;
          core_data <= mem[0];
        end
        LOAD: begin
          if (wcnt == 4'd15) begin
            state     <= WAIT;
            core_data <= 32'h0;
            tcnt      <= '0;
          end else begin
            wcnt      <= wcnt + 4'd1;
            core_data <= mem[wcnt + 4'd1];
          end
        end
        WAIT: begin
          if (core_eoc) begin
            if (blk_left == 4'd1) begin
              state   <= READ;
              core_rd <= 1'b1;
              rcnt    <= 4'd0;
            end else begin
              state    <= FILL;
              blk_left <= blk_left - 4'd1;
              wcnt     <= 4'd0;
              s_ready  <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        READ: begin
          // rcnt 0..7 are core_rd cycles; rcnt 8 is the cycle H7 is presented.
          if (rcnt == 4'd7) core_rd <= 1'b0;
          if (rcnt == 4'd8) begin
            state <= IDLE;
            rcnt  <= 4'd0;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            rcnt <= rcnt + 4'd1;
          end
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_kdf_seq.sv
// Scoreboard bench for sha256_kdf_seq: directed messages in, a behavioural SHA core stub, expected events popped by a monitor.
module tb_sha256_kdf_seq;

  localparam int TIMEOUT = 64;
  localparam int MAX_BLK = 15;

  typedef enum int {K_H, K_DONE, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] dat;
    logic        last;
    int          rel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  nblocks = 4'd0;
  logic [31:0] s_data = 32'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] core_data;
  logic        core_soc;
  logic        core_rd;
  logic        core_eoc = 1'b0;
  logic [31:0] core_hash = 32'h0;
  logic [31:0] h_data;
  logic        h_valid;
  logic        h_last;
  logic        busy;
  logic        done;
  logic        err;

  sha256_kdf_seq #(.TIMEOUT(TIMEOUT), .MAX_BLK(MAX_BLK)) dut (
    .clk(clk), .rst(rst), .start(start), .nblocks(nblocks),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_data(core_data), .core_soc(core_soc), .core_rd(core_rd),
    .core_eoc(core_eoc), .core_hash(core_hash),
    .h_data(h_data), .h_valid(h_valid), .h_last(h_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] core_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int win = 0, pend = 0, ecnt = 0;
  int eoc_delay = 48, eoc_cnt = 0, rd_idx = 0, cur_nblk = 0, soc_cnt = 0;
  int load_end_cyc = 0, h7_cyc = -10, err_cyc = -10;
  logic [31:0] dig_base = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event or timeout, want none (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [31:0] word(input int id, input int b, input int w);
    return 32'((id << 24) | (b << 16) | (32'hA5 << 8) | w);
  endfunction

  task automatic push_ev(input kind_t k, input logic [31:0] d, input logic l, input int rel);
    exp_t e;
    e.kind = k; e.dat = d; e.last = l; e.rel = rel;
    exp_q.push_back(e);
  endtask

  // mode 0: normal digest, 1: rejected start, 2: core timeout on the first block
  task automatic push_expect(input int n, input int id, input int mode);
    cur_nblk = n; eoc_cnt = 0; rd_idx = 0; soc_cnt = 0;
    dig_base = 32'hD1600000 + 32'(id << 8);
    if (mode == 1) begin
      push_ev(K_ERR, 32'h0, 1'b0, -1);
    end else begin
      for (int b = 0; b < n; b++)
        for (int w = 0; w < 16; w++) core_q.push_back(word(id, b, w));
      if (mode == 2) begin
        push_ev(K_ERR, 32'h0, 1'b0, TIMEOUT + 1);
      end else begin
        for (int i = 0; i < 8; i++) push_ev(K_H, dig_base + 32'(i), i == 7, -1);
        push_ev(K_DONE, 32'h0, 1'b0, -1);
      end
    end
  endtask

  task automatic start_msg(input int n);
    @(posedge clk); #1;
    start = 1'b1; nblocks = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int id, input bit toggle);
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < 16; w++) begin
        int t;
        t = 0;
        s_data = word(id, b, w); s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && t < 300) begin t++; @(negedge clk); end
        if (!s_ready) begin
          fail("s_ready_wait");
          s_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (toggle) begin
          s_data = 32'hDEADBEEF;
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && t < 2000) begin t++; @(negedge clk); end
    if (exp_q.size() != 0 || busy) fail(nm);
    chk({nm, "_core_q_drained"}, 32'(core_q.size()), 32'd0);
  endtask

  // Core stub and scoreboard monitor share the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    core_eoc = 1'b0;
    if (!rst) begin
      win = 0; pend = 0; core_hash = 32'h0;
    end else begin
      if (pend != 0) begin
        ecnt++;
        if (ecnt == eoc_delay) begin core_eoc = 1'b1; eoc_cnt++; pend = 0; end
      end
      if (win > 0) begin
        if (core_q.size() == 0) fail("core_data_unexpected");
        else chk("core_data", core_data, core_q.pop_front());
        win--;
        if (win == 0) begin pend = 1; ecnt = 0; load_end_cyc = cyc; end
      end else begin
        chk("core_data_idle_zero", core_data, 32'h0);
      end
      if (core_soc) begin
        soc_cnt++;
        if (win != 0 || core_q.size() < 16) fail("core_soc_unexpected");
        win = 16;
      end
      if (core_rd) begin
        chk("rd_after_last_eoc", 32'(eoc_cnt), 32'(cur_nblk));
        core_hash = dig_base + 32'(rd_idx);
        rd_idx++;
      end else begin
        core_hash = 32'h0;
      end
      if (h_valid) begin
        if (exp_q.size() == 0) fail("h_valid_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("h_kind", 32'(int'(e.kind)), 32'(int'(K_H)));
          chk("h_data", h_data, e.dat);
          chk("h_last", 32'(h_last), 32'(e.last));
        end
        if (h_last) h7_cyc = cyc;
      end
      if (done) begin
        if (exp_q.size() == 0) fail("done_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("done_kind", 32'(int'(e.kind)), 32'(int'(K_DONE)));
          chk("done_after_h7", 32'(cyc - h7_cyc), 32'd1);
        end
      end
      if (err) begin
        if (exp_q.size() == 0) fail("err_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("err_kind", 32'(int'(e.kind)), 32'(int'(K_ERR)));
          if (e.rel >= 0) chk("err_timeout_cycle", 32'(cyc - load_end_cyc), 32'(e.rel));
        end
        err_cyc = cyc;
      end
      if (cyc == err_cyc + 1) chk("busy_after_err", 32'(busy), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {24'h0, s_ready, core_soc, core_rd, h_valid, h_last, busy, done, err}, 32'h0);
    chk("reset_core_data", core_data, 32'h0);
    chk("reset_h_data", h_data, 32'h0);
    rst = 1'b1;

    // Single block, back-to-back words
    eoc_delay = 48;
    push_expect(1, 1, 0); start_msg(1); feed(1, 1, 1'b0);
    wait_idle("one_block");
    chk("one_block_soc_count", 32'(soc_cnt), 32'd1);

    // Three blocks with gapped s_valid
    push_expect(3, 2, 0); start_msg(3); feed(3, 2, 1'b1);
    wait_idle("three_block");
    chk("three_block_soc_count", 32'(soc_cnt), 32'd3);

    // Zero block count is rejected
    push_expect(0, 3, 1); start_msg(0);
    wait_idle("zero_block");
    chk("zero_block_soc_count", 32'(soc_cnt), 32'd0);

    // Core never signals end of compression
    eoc_delay = -1;
    push_expect(1, 4, 2); start_msg(1); feed(1, 4, 1'b0);
    wait_idle("timeout");
    chk("timeout_no_rd", 32'(rd_idx), 32'd0);
    eoc_delay = 48;

    // Reset during LOAD of block 2
    begin
      int t;
      push_expect(2, 5, 0); start_msg(2); feed(2, 5, 1'b0);
      t = 0;
      while (!core_soc && t < 300) begin t++; @(negedge clk); end
      if (!core_soc) fail("block2_soc_wait");
      repeat (4) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_ctrl", {24'h0, s_ready, core_soc, core_rd, h_valid, h_last, busy, done, err}, 32'h0);
      chk("abort_core_data", core_data, 32'h0);
      exp_q.delete();
      core_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
    end
    push_expect(1, 7, 0); start_msg(1); feed(1, 7, 1'b0);
    wait_idle("after_abort");

    // Start pulsed during READ is ignored
    push_expect(1, 6, 0); start_msg(1);
    fork
      feed(1, 6, 1'b0);
      begin
        int t;
        t = 0;
        while (!core_rd && t < 500) begin t++; @(negedge clk); end
        @(posedge clk); #1;
        start = 1'b1; nblocks = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_idle("start_in_read");
    repeat (6) @(negedge clk);
    chk("ignored_start_busy", 32'(busy), 32'd0);
    chk("ignored_start_s_ready", 32'(s_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
